ddr_pkt_rd_buf: RTL and testbench

Parametrised successor to the DDR-read loopback buffer. It accepts DDR read-return beats into an on-chip RAM organised as NUM_SLOTS packet slots, each BEATS_PER_PKT beats deep. It tracks two counts: packets requested (via accepted read commands) and packets landed (via returned data). From these it drives buf_full back-pressure toward the DDR read scheduler and pkt_ready toward the image-side consumer. Unlike its predecessor, it runs on one clock, has configurable width/depth/slot count, a registered read port with a valid flag, live occupancy counters, and sticky overflow/underflow error flags.

---
 rtl/ddr_pkt_rd_buf_if.sv | 38 +++
 rtl/ddr_pkt_rd_buf.sv | 117 +++++++++++
 tb/tb_ddr_pkt_rd_buf.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_pkt_rd_buf_if.sv
// rtl/ddr_pkt_rd_buf_if.sv - DDR UI command/read-return and consumer-side bundle for ddr_pkt_rd_buf
interface ddr_pkt_rd_buf_if #(
    parameter int DATA_W = 512,
    parameter int BEAT_W = 3,
    parameter int CNT_W  = 3
);
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic              rd_en;
    logic [BEAT_W-1:0] rd_beat;
    logic              rd_pkt_done;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              pkt_ready;
    logic              buf_full;
    logic [CNT_W-1:0]  cmd_pkts;
    logic [CNT_W-1:0]  data_pkts;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output app_cmd, app_en, app_rdy, app_rd_data, app_rd_data_valid,
               rd_en, rd_beat, rd_pkt_done, clr_err,
        input  rd_data, rd_data_valid, pkt_ready, buf_full,
               cmd_pkts, data_pkts, ovf_err, unf_err
    );

    modport slave (
        input  app_cmd, app_en, app_rdy, app_rd_data, app_rd_data_valid,
               rd_en, rd_beat, rd_pkt_done, clr_err,
        output rd_data, rd_data_valid, pkt_ready, buf_full,
               cmd_pkts, data_pkts, ovf_err, unf_err
    );
endinterface

// File: rtl/ddr_pkt_rd_buf.sv
// rtl/ddr_pkt_rd_buf.sv - slotted packet buffer for DDR read returns with request/landed packet accounting
module ddr_pkt_rd_buf #(
    parameter int         DATA_W        = 512,
    parameter int         BEATS_PER_PKT = 5,
    parameter int         NUM_SLOTS     = 4,
    parameter logic [2:0] RD_CMD        = 3'd1,
    parameter int         BEAT_W        = $clog2(BEATS_PER_PKT),
    parameter int         ADDR_W        = $clog2(BEATS_PER_PKT * NUM_SLOTS),
    parameter int         CNT_W         = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    ddr_pkt_rd_buf_if.slave  bus
);
    localparam int                DEPTH     = BEATS_PER_PKT * NUM_SLOTS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_PKT - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [ADDR_W-1:0] SLOT_STEP = ADDR_W'(BEATS_PER_PKT);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(BEATS_PER_PKT * (NUM_SLOTS - 1));
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_SLOTS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [BEAT_W-1:0] cmd_beat;
    logic [CNT_W-1:0]  cmd_pkts_q, data_pkts_q;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [BEAT_W-1:0] wr_beat;
    logic [ADDR_W-1:0] wr_base, rd_base;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, ovf_q, unf_q;

    logic              cmd_acc, full, cmd_drop, cmd_done;
    logic              wr_drop, wr_ok, wr_done, rel, unf;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    always_comb begin
        cmd_acc  = bus.app_en & bus.app_rdy & (bus.app_cmd == RD_CMD);
        full     = (cmd_pkts_q == FULL_CNT);
        cmd_drop = cmd_acc & (cmd_beat == '0) & full;
        cmd_done = cmd_acc & ~cmd_drop & (cmd_beat == LAST_BEAT);
        // Only the first beat of a slot is gated; later beats belong to a slot already claimed.
        wr_drop  = wr_en & (wr_beat == '0) & (data_pkts_q == FULL_CNT);
        wr_ok    = wr_en & ~wr_drop;
        wr_done  = wr_ok & (wr_beat == LAST_BEAT);
        rel      = bus.rd_pkt_done & (data_pkts_q != '0);
        unf      = bus.rd_pkt_done & (data_pkts_q == '0);
        wr_addr  = wr_base + ADDR_W'(wr_beat);
        rd_addr  = rd_base + ADDR_W'(bus.rd_beat);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_beat    <= '0;
            cmd_pkts_q  <= '0;
            data_pkts_q <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            wr_beat     <= '0;
            wr_base     <= '0;
            rd_base     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_en   <= bus.app_rd_data_valid;
            wr_data <= bus.app_rd_data;

            if (cmd_acc && !cmd_drop)
                cmd_beat <= (cmd_beat == LAST_BEAT) ? '0 : cmd_beat + BEAT_ONE;

            if (cmd_done && !rel)
                cmd_pkts_q <= cmd_pkts_q + CNT_ONE;
            else if (rel && !cmd_done)
                cmd_pkts_q <= cmd_pkts_q - CNT_ONE;

            if (wr_done && !rel)
                data_pkts_q <= data_pkts_q + CNT_ONE;
            else if (rel && !wr_done)
                data_pkts_q <= data_pkts_q - CNT_ONE;

            if (wr_done) begin
                wr_beat <= '0;
                wr_base <= (wr_base == LAST_BASE) ? '0 : wr_base + SLOT_STEP;
            end else if (wr_ok) begin
                wr_beat <= wr_beat + BEAT_ONE;
            end

            if (rel)
                rd_base <= (rd_base == LAST_BASE) ? '0 : rd_base + SLOT_STEP;

            if (bus.rd_en)
                rd_data_q <= mem[rd_addr];
            rd_valid_q <= bus.rd_en;

            // A new error on the same edge as clr_err keeps the flag set.
            ovf_q <= (ovf_q & ~bus.clr_err) | cmd_drop | wr_drop;
            unf_q <= (unf_q & ~bus.clr_err) | unf;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.pkt_ready     = (data_pkts_q != '0);
    assign bus.buf_full      = full;
    assign bus.cmd_pkts      = cmd_pkts_q;
    assign bus.data_pkts     = data_pkts_q;
    assign bus.ovf_err       = ovf_q;
    assign bus.unf_err       = unf_q;
endmodule

// File: tb/tb_ddr_pkt_rd_buf.sv
// tb/tb_ddr_pkt_rd_buf.sv - directed self-checking bench for ddr_pkt_rd_buf
module tb_ddr_pkt_rd_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ddr_pkt_rd_buf_if #(.DATA_W(512), .BEAT_W(3), .CNT_W(3)) bus ();

    ddr_pkt_rd_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [511:0] mk(input int p, input int b);
        logic [15:0] ph, bl;
        ph = p[15:0];
        bl = b[15:0];
        return {16{ph, bl}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmds(input int n, input logic [2:0] cmd = 3'd1, input logic rdy = 1'b1);
        bus.app_en  = 1'b1;
        bus.app_rdy = rdy;
        bus.app_cmd = cmd;
        repeat (n) cyc();
        bus.app_en  = 1'b0;
        bus.app_rdy = 1'b0;
        bus.app_cmd = 3'd0;
    endtask

    task automatic land(input int p);
        for (int b = 0; b < 5; b++) begin
            bus.app_rd_data_valid = 1'b1;
            bus.app_rd_data       = mk(p, b);
            cyc();
        end
        bus.app_rd_data_valid = 1'b0;
    endtask

    task automatic read_chk(input int p, input int b);
        bus.rd_en   = 1'b1;
        bus.rd_beat = 3'(b);
        cyc();
        bus.rd_en   = 1'b0;
        check($sformatf("rd_valid p%0d b%0d", p, b), 512'(bus.rd_data_valid), 512'(1));
        check($sformatf("rd_data p%0d b%0d", p, b), bus.rd_data, mk(p, b));
    endtask

    task automatic done();
        bus.rd_pkt_done = 1'b1;
        cyc();
        bus.rd_pkt_done = 1'b0;
    endtask

    task automatic clr();
        bus.clr_err = 1'b1;
        cyc();
        bus.clr_err = 1'b0;
    endtask

    task automatic read_pkt(input int p);
        for (int b = 0; b < 5; b++) read_chk(p, b);
        done();
    endtask

    initial begin
        bus.app_cmd = 3'd0; bus.app_en = 1'b0; bus.app_rdy = 1'b0;
        bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
        bus.rd_en = 1'b0; bus.rd_beat = '0; bus.rd_pkt_done = 1'b0; bus.clr_err = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        check("rst rd_data", bus.rd_data, '0);
        check("rst rd_valid", 512'(bus.rd_data_valid), '0);
        check("rst pkt_ready", 512'(bus.pkt_ready), '0);
        check("rst buf_full", 512'(bus.buf_full), '0);
        check("rst cmd_pkts", 512'(bus.cmd_pkts), '0);
        check("rst data_pkts", 512'(bus.data_pkts), '0);
        check("rst ovf", 512'(bus.ovf_err), '0);
        check("rst unf", 512'(bus.unf_err), '0);

        // Mid-packet asynchronous reset
        done();
        check("pre-rst unf", 512'(bus.unf_err), 512'(1));
        cmds(3);
        rst_n = 1'b0;
        #1;
        check("async rst unf", 512'(bus.unf_err), '0);
        check("async rst cmd_pkts", 512'(bus.cmd_pkts), '0);
        check("async rst buf_full", 512'(bus.buf_full), '0);
        cyc();
        rst_n = 1'b1;
        cmds(4);
        check("post-rst 4 cmds", 512'(bus.cmd_pkts), '0);
        cmds(1);
        check("post-rst 5 cmds", 512'(bus.cmd_pkts), 512'(1));

        // Single packet
        cmds(5, 3'd0, 1'b1);
        cmds(5, 3'd1, 1'b0);
        check("non-read cmds ignored", 512'(bus.cmd_pkts), 512'(1));
        land(1);
        check("pkt_ready at E", 512'(bus.pkt_ready), '0);
        cyc();
        check("pkt_ready at E+1", 512'(bus.pkt_ready), 512'(1));
        check("data_pkts single", 512'(bus.data_pkts), 512'(1));
        for (int b = 0; b < 5; b++) read_chk(1, b);
        cyc();
        check("rd_valid one cycle", 512'(bus.rd_data_valid), '0);
        check("rd_data holds", bus.rd_data, mk(1, 4));
        done();
        check("release pkt_ready", 512'(bus.pkt_ready), '0);
        check("release cmd_pkts", 512'(bus.cmd_pkts), '0);
        check("release data_pkts", 512'(bus.data_pkts), '0);

        // Full / back-pressure
        cmds(20);
        check("full cmd_pkts", 512'(bus.cmd_pkts), 512'(4));
        check("full buf_full", 512'(bus.buf_full), 512'(1));
        cmds(1);
        check("cmd ovf flag", 512'(bus.ovf_err), 512'(1));
        check("cmd ovf cmd_pkts", 512'(bus.cmd_pkts), 512'(4));
        land(2);
        cyc();
        read_chk(2, 3);
        done();
        check("full release buf_full", 512'(bus.buf_full), '0);
        check("full release cmd_pkts", 512'(bus.cmd_pkts), 512'(3));
        clr();
        check("ovf cleared", 512'(bus.ovf_err), '0);
        cmds(4);
        check("dropped cmd left beat at 0", 512'(bus.cmd_pkts), 512'(3));

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Wrap-around across slots 0,1,2,3,0,1 with a dropped over-full packet
        cmds(20);
        land(10); land(11); land(12); land(13);
        cyc();
        check("wrap data_pkts full", 512'(bus.data_pkts), 512'(4));
        land(99);
        cyc();
        check("wr drop data_pkts", 512'(bus.data_pkts), 512'(4));
        check("wr drop ovf", 512'(bus.ovf_err), 512'(1));
        clr();
        read_pkt(10);
        cmds(5);
        land(14);
        read_pkt(11);
        cmds(5);
        land(15);
        read_pkt(12);
        read_pkt(13);
        read_pkt(14);
        read_pkt(15);
        check("wrap end data_pkts", 512'(bus.data_pkts), '0);
        check("wrap end cmd_pkts", 512'(bus.cmd_pkts), '0);
        check("wrap end pkt_ready", 512'(bus.pkt_ready), '0);

        // Simultaneous increment and decrement
        cmds(15);
        land(20);
        land(21);
        cyc();
        check("simul pre data_pkts", 512'(bus.data_pkts), 512'(2));
        land(22);
        bus.rd_pkt_done = 1'b1;
        cyc();
        bus.rd_pkt_done = 1'b0;
        check("simul wr data_pkts", 512'(bus.data_pkts), 512'(2));
        check("simul wr cmd_pkts", 512'(bus.cmd_pkts), 512'(2));
        cmds(4);
        bus.app_en = 1'b1; bus.app_rdy = 1'b1; bus.app_cmd = 3'd1;
        bus.rd_pkt_done = 1'b1;
        cyc();
        bus.app_en = 1'b0; bus.app_rdy = 1'b0; bus.app_cmd = 3'd0;
        bus.rd_pkt_done = 1'b0;
        check("simul cmd cmd_pkts", 512'(bus.cmd_pkts), 512'(2));
        check("simul cmd data_pkts", 512'(bus.data_pkts), 512'(1));
        read_chk(22, 4);
        read_chk(22, 0);

        // Underflow and clear
        done();
        check("unf pre data_pkts", 512'(bus.data_pkts), '0);
        done();
        check("unf flag", 512'(bus.unf_err), 512'(1));
        check("unf data_pkts", 512'(bus.data_pkts), '0);
        check("unf cmd_pkts", 512'(bus.cmd_pkts), 512'(1));
        clr();
        check("unf cleared", 512'(bus.unf_err), '0);
        bus.clr_err = 1'b1;
        bus.rd_pkt_done = 1'b1;
        cyc();
        bus.clr_err = 1'b0;
        bus.rd_pkt_done = 1'b0;
        check("unf set wins", 512'(bus.unf_err), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
